// File: rtl/read_region_strided.sv
// Region reader: streams cache lines from a BRAM or FIFO region with a signed
// per-iteration stride, a bounded outstanding-read credit, abort and busy/done status.
module read_region_strided #(
    parameter int ADDR_WIDTH      = 14,
    parameter int LEN_WIDTH       = 14,
    parameter int ITER_WIDTH      = 16,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  op_start,
    input  logic [1:0]            cfg_mode,
    input  logic [ADDR_WIDTH-1:0] cfg_offset,
    input  logic [LEN_WIDTH-1:0]  cfg_length,
    input  logic [ITER_WIDTH-1:0] cfg_iterations,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic                  op_abort,
    output logic                  op_busy,
    output logic                  op_done,
    output logic                  op_aborted,
    output logic                  region_re,
    output logic [1:0]            region_rfifobram,
    output logic [ADDR_WIDTH-1:0] region_raddr,
    input  logic                  region_empty,
    input  logic                  region_rvalid,
    input  logic [DATA_WIDTH-1:0] region_rdata,
    output logic                  out_rvalid,
    output logic [DATA_WIDTH-1:0] out_rdata,
    input  logic                  out_almostfull
);

    localparam int OUT_WIDTH = $clog2(MAX_OUTSTANDING) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] MODE_BRAM = 2'b01;
    localparam logic [1:0] MODE_FIFO = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            r_mode;
    logic [LEN_WIDTH-1:0]  r_length;
    logic [ITER_WIDTH-1:0] r_iterations;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_line;
    logic [ITER_WIDTH-1:0] r_iter;
    logic [OUT_WIDTH-1:0]  r_outstanding;
    logic                  r_aborted;
    logic                  r_noop_done;
    logic                  r_out_rvalid;
    logic [DATA_WIDTH-1:0] r_out_rdata;

    logic w_mode_bram;
    logic w_mode_fifo;
    logic w_cfg_valid;
    logic w_credit_ok;
    logic w_issue;
    logic w_abort;
    logic w_last_line;
    logic w_last_iter;
    logic w_return;
    logic w_drain_done;

    assign w_mode_bram  = (r_mode == MODE_BRAM);
    assign w_mode_fifo  = (r_mode == MODE_FIFO);
    assign w_cfg_valid  = ((cfg_mode == MODE_BRAM) || (cfg_mode == MODE_FIFO)) &&
                          (cfg_length != '0) && (cfg_iterations != '0);
    assign w_credit_ok  = (r_outstanding < OUT_WIDTH'(MAX_OUTSTANDING));
    assign w_abort      = (r_state == S_ISSUE) && op_abort;
    assign w_issue      = (r_state == S_ISSUE) && !op_abort && !out_almostfull &&
                          w_credit_ok && !(w_mode_fifo && region_empty);
    assign w_last_line  = (r_line == (r_length - LEN_WIDTH'(1)));
    assign w_last_iter  = (r_iter == (r_iterations - ITER_WIDTH'(1)));
    // Returns with nothing in flight (e.g. stale data after a reset) are forwarded but not counted.
    assign w_return     = region_rvalid && (r_outstanding != '0);
    assign w_drain_done = (r_state == S_DRAIN) && (r_outstanding == '0);

    // Request outputs are combinational so back-pressure, empty and abort act in the same cycle.
    assign region_re        = w_issue;
    assign region_rfifobram = w_issue ? r_mode : 2'b00;
    assign region_raddr     = (w_issue && w_mode_bram) ? (r_base + ADDR_WIDTH'(r_line)) : '0;

    assign op_busy    = (r_state != S_IDLE);
    assign op_done    = r_noop_done || w_drain_done;
    assign op_aborted = w_drain_done && r_aborted;

    assign out_rvalid = r_out_rvalid;
    assign out_rdata  = r_out_rdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_mode       <= 2'b00;
            r_length     <= '0;
            r_iterations <= '0;
            r_stride     <= '0;
            r_base       <= '0;
            r_line       <= '0;
            r_iter       <= '0;
            r_aborted    <= 1'b0;
            r_noop_done  <= 1'b0;
        end else begin
            r_noop_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (op_start) begin
                        r_mode       <= cfg_mode;
                        r_length     <= cfg_length;
                        r_iterations <= cfg_iterations;
                        r_stride     <= cfg_stride;
                        r_base       <= cfg_offset;
                        r_line       <= '0;
                        r_iter       <= '0;
                        r_aborted    <= 1'b0;
                        if (w_cfg_valid) begin
                            r_state <= S_ISSUE;
                        end else begin
                            r_noop_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= S_DRAIN;
                    end else if (w_issue) begin
                        if (w_last_line) begin
                            r_line <= '0;
                            r_iter <= r_iter + ITER_WIDTH'(1);
                            // Stride is two's complement, so a plain wrap-around add applies it signed.
                            if (w_mode_bram) begin
                                r_base <= r_base + r_stride;
                            end
                            if (w_last_iter) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_line <= r_line + LEN_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_aborted <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_issue, w_return})
                2'b10:   r_outstanding <= r_outstanding + OUT_WIDTH'(1);
                2'b01:   r_outstanding <= r_outstanding - OUT_WIDTH'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_rvalid <= 1'b0;
            r_out_rdata  <= '0;
        end else begin
            r_out_rvalid <= region_rvalid;
            r_out_rdata  <= region_rdata;
        end
    end

endmodule

// File: tb/tb_read_region_strided.sv
// Bench for read_region_strided: two instances (credit 8 and credit 2) behind one
// latency-programmable region model, checked against an arithmetic address model.
module tb_read_region_strided;

    localparam int AW = 14;
    localparam int LW = 14;
    localparam int IW = 16;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          op_start = 1'b0;
    logic          op_abort = 1'b0;
    logic          region_empty = 1'b0;
    logic          out_almostfull = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic [AW-1:0] cfg_offset = '0;
    logic [AW-1:0] cfg_stride = '0;
    logic [LW-1:0] cfg_length = '0;
    logic [IW-1:0] cfg_iterations = '0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic          sel = 1'b0;

    logic          d_start [2];
    logic          d_rvalid[2];
    logic          d_busy  [2];
    logic          d_done  [2];
    logic          d_ab    [2];
    logic          d_re    [2];
    logic          d_orv   [2];
    logic [1:0]    d_fb    [2];
    logic [AW-1:0] d_raddr [2];
    logic [DW-1:0] d_ord   [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        assign d_start[gi]  = op_start && (sel == 1'(gi));
        assign d_rvalid[gi] = m_rvalid && (sel == 1'(gi));
        read_region_strided #(
            .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ITER_WIDTH(IW), .DATA_WIDTH(DW),
            .MAX_OUTSTANDING((gi == 0) ? 8 : 2)
        ) u_dut (
            .clk(clk), .reset_n(reset_n), .op_start(d_start[gi]), .cfg_mode(cfg_mode),
            .cfg_offset(cfg_offset), .cfg_length(cfg_length), .cfg_iterations(cfg_iterations),
            .cfg_stride(cfg_stride), .op_abort(op_abort), .op_busy(d_busy[gi]),
            .op_done(d_done[gi]), .op_aborted(d_ab[gi]), .region_re(d_re[gi]),
            .region_rfifobram(d_fb[gi]), .region_raddr(d_raddr[gi]),
            .region_empty(region_empty), .region_rvalid(d_rvalid[gi]), .region_rdata(m_rdata),
            .out_rvalid(d_orv[gi]), .out_rdata(d_ord[gi]), .out_almostfull(out_almostfull)
        );
    end

    logic          s_re, s_busy, s_done, s_ab, s_orv;
    logic [1:0]    s_fb;
    logic [AW-1:0] s_raddr;
    logic [DW-1:0] s_ord;
    always_comb begin
        s_re    = d_re[sel];
        s_busy  = d_busy[sel];
        s_done  = d_done[sel];
        s_ab    = d_ab[sel];
        s_orv   = d_orv[sel];
        s_fb    = d_fb[sel];
        s_raddr = d_raddr[sel];
        s_ord   = d_ord[sel];
    end

    int            n_assert = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            n_issued = 0, n_ret = 0, n_out = 0, n_done = 0, n_total = 0;
    int            done_cyc = -1, last_rv_cyc = -100, first_iss = 0, last_iss = 0;
    int            lat = 2, cur_max = 8;
    logic          done_ab = 1'b0;
    bit            track = 1'b0;
    logic [1:0]    cur_mode = 2'b01;
    logic [31:0]   salt = 32'h0;
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] sched[int];
    logic          prev_rv = 1'b0;
    logic [DW-1:0] prev_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] tok(input int k);
        return {16{32'(k) ^ salt}};
    endfunction

    // Region model: a read issued in cycle c returns in cycle c+lat; idle cycles carry junk data.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (sched.exists(cyc)) begin
            m_rvalid = 1'b1;
            m_rdata  = sched[cyc];
            sched.delete(cyc);
        end else begin
            m_rvalid = 1'b0;
            m_rdata  = {16{$urandom}};
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("fwd_valid", 64'(s_orv), 64'(prev_rv));
            chk_data("fwd_data", s_ord, prev_rd);
            if (track && s_orv) begin
                chk_data("beat_order", s_ord, tok(n_out));
                n_out++;
            end
            if (s_re) begin
                if (track) begin
                    chk("req_fifobram", 64'(s_fb), 64'(cur_mode));
                    chk("req_within_total", 64'(n_issued < n_total), 64'(1));
                    if (n_issued < n_total)
                        chk("req_addr", 64'(s_raddr),
                            (cur_mode == 2'b01) ? 64'(exp_addr[n_issued]) : 64'(0));
                    chk("req_under_almostfull", 64'(out_almostfull), 64'(0));
                    if (cur_mode == 2'b10)
                        chk("req_while_empty", 64'(region_empty), 64'(0));
                    chk("req_credit", 64'((n_issued - n_ret) < cur_max), 64'(1));
                    if (n_issued == 0) first_iss = cyc;
                    last_iss = cyc;
                end
                sched[cyc + lat] = tok(n_issued);
                n_issued++;
            end else begin
                chk("idle_fifobram", 64'(s_fb), 64'(0));
            end
            if (m_rvalid) begin
                n_ret++;
                last_rv_cyc = cyc;
            end
            if (s_done) begin
                n_done++;
                done_cyc = cyc;
                done_ab  = s_ab;
            end
        end
        prev_rv = m_rvalid;
        prev_rd = m_rdata;
    end

    task automatic run(input logic [1:0] mode, input logic [AW-1:0] off, input logic [LW-1:0] len,
                       input logic [IW-1:0] its, input logic [AW-1:0] stride, input int l,
                       input logic s, input int abort_at, input bit fifo_tog,
                       input int af_lo, input int af_hi, input bit consec);
        bit noop;
        bit ab_sent;
        int rel;
        int start_cyc;
        int abort_cyc;
        int exp_done;
        noop    = !((mode == 2'b01) || (mode == 2'b10)) || (len == '0) || (its == '0);
        n_total = noop ? 0 : int'(len) * int'(its);
        if (!(abort_at >= 0 && abort_at < n_total)) abort_at = -1;
        if (abort_at >= 0) n_total = abort_at;
        exp_addr.delete();
        for (int k = 0; k < n_total; k++)
            exp_addr.push_back(AW'(int'(off) + (k / int'(len)) * int'($signed(stride)) + (k % int'(len))));

        @(posedge clk); #1;
        sel = s; lat = l; cur_max = s ? 2 : 8; cur_mode = mode; salt = $urandom;
        n_issued = 0; n_ret = 0; n_out = 0; n_done = 0; done_cyc = -1; done_ab = 1'b0;
        last_rv_cyc = -100; first_iss = 0; last_iss = 0; track = 1'b1;
        cfg_mode = mode; cfg_offset = off; cfg_length = len; cfg_iterations = its; cfg_stride = stride;
        op_start = 1'b1;
        start_cyc = cyc;
        abort_cyc = -100;
        ab_sent = 1'b0;
        rel = 0;
        @(posedge clk); #1;
        op_start = 1'b0;
        while ((n_done == 0 || rel < 3) && rel < 400) begin
            region_empty   = (mode == 2'b10) ? (fifo_tog && rel[0]) : 1'($urandom);
            out_almostfull = (rel >= af_lo) && (rel <= af_hi);
            op_abort       = 1'b0;
            if (abort_at >= 0 && !ab_sent && n_issued >= abort_at) begin
                op_abort  = 1'b1;
                ab_sent   = 1'b1;
                abort_cyc = cyc;
            end
            chk("busy", 64'(s_busy), 64'(!noop && n_done == 0));
            @(posedge clk); #1;
            rel++;
        end
        op_abort = 1'b0; out_almostfull = 1'b0; region_empty = 1'b0;

        exp_done = noop ? start_cyc + 1 : ((last_rv_cyc > abort_cyc) ? last_rv_cyc : abort_cyc) + 1;
        chk("done_pulses", 64'(n_done), 64'(1));
        chk("req_count", 64'(n_issued), 64'(n_total));
        chk("beat_count", 64'(n_out), 64'(n_total));
        chk("done_aborted", 64'(done_ab), 64'(abort_at >= 0));
        chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        if (consec) chk("back_to_back", 64'(last_iss - first_iss), 64'(n_total - 1));
        $display("run mode=%0d off=%0d len=%0d iters=%0d stride=%0d lat=%0d credit=%0d issued=%0d beats=%0d done_cyc=%0d aborted=%0b",
                 mode, off, len, its, $signed(stride), l, cur_max, n_issued, n_out, done_cyc, done_ab);
    endtask

    task automatic chk_reset_outputs(input string phase);
        chk({phase, "_busy"}, 64'(s_busy), 64'(0));
        chk({phase, "_done"}, 64'(s_done), 64'(0));
        chk({phase, "_aborted"}, 64'(s_ab), 64'(0));
        chk({phase, "_re"}, 64'(s_re), 64'(0));
        chk({phase, "_fifobram"}, 64'(s_fb), 64'(0));
        chk({phase, "_raddr"}, 64'(s_raddr), 64'(0));
        chk({phase, "_out_rvalid"}, 64'(s_orv), 64'(0));
        chk_data({phase, "_out_rdata"}, s_ord, '0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2 chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run(2'b01, 14'd5, 14'd3, 16'd2, 14'd3, 2, 1'b0, -1, 1'b0, 100, 0, 1'b1);
        run(2'b01, 14'd2, 14'd2, 16'd3, 14'h3FFC, 2, 1'b0, -1, 1'b0, 100, 0, 1'b1);
        run(2'b10, 14'd0, 14'd4, 16'd1, 14'd0, 2, 1'b0, -1, 1'b1, 3, 5, 1'b0);
        run(2'b01, 14'd100, 14'd8, 16'd1, 14'd0, 6, 1'b1, -1, 1'b0, 100, 0, 1'b0);
        run(2'b01, 14'd40, 14'd10, 16'd1, 14'd0, 4, 1'b0, 3, 1'b0, 100, 0, 1'b0);
        run(2'b01, 14'd7, 14'd4, 16'd2, 14'd9, 3, 1'b0, -1, 1'b0, 100, 0, 1'b1);
        run(2'b01, 14'd5, 14'd0, 16'd2, 14'd1, 2, 1'b0, -1, 1'b0, 100, 0, 1'b0);
        run(2'b00, 14'd5, 14'd4, 16'd2, 14'd1, 2, 1'b0, -1, 1'b0, 100, 0, 1'b0);
        run(2'b11, 14'd5, 14'd4, 16'd1, 14'd1, 2, 1'b1, -1, 1'b0, 100, 0, 1'b0);
        run(2'b10, 14'd0, 14'd3, 16'd0, 14'd0, 2, 1'b0, -1, 1'b0, 100, 0, 1'b0);

        for (int r = 0; r < 10; r++) begin
            logic [LW-1:0] len_r;
            logic [IW-1:0] its_r;
            int            ab_r;
            int            lo_r;
            len_r = LW'($urandom_range(1, 6));
            its_r = IW'($urandom_range(1, 3));
            ab_r  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, int'(len_r) * int'(its_r))) : -1;
            lo_r  = int'($urandom_range(0, 8));
            run(2'($urandom_range(1, 2)), AW'($urandom), len_r, its_r, AW'($urandom),
                int'($urandom_range(1, 6)), 1'($urandom), ab_r, 1'($urandom),
                lo_r, lo_r + int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of a long run with reads still in flight.
        @(posedge clk); #1;
        sel = 1'b0; lat = 3; cur_mode = 2'b01; track = 1'b0; n_issued = 0;
        cfg_mode = 2'b01; cfg_offset = 14'd50; cfg_length = 14'd100; cfg_iterations = 16'd1;
        cfg_stride = 14'd0; op_start = 1'b1;
        @(posedge clk); #1;
        op_start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("midrun_reset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (8) @(posedge clk);
        chk("post_reset_busy", 64'(s_busy), 64'(0));
        run(2'b01, 14'd16380, 14'd3, 16'd2, 14'd1, 3, 1'b0, -1, 1'b0, 100, 0, 1'b1);
        run(2'b10, 14'd0, 14'd5, 16'd2, 14'd0, 5, 1'b1, -1, 1'b1, 2, 4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
